// File: rtl/alu_pkg.sv
// alu_pkg: opcode encoding and legality helper for the shared ALU.
package alu_pkg;
    localparam int ALU_OP_W = 3;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 3'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'd3;
    function automatic logic alu_op_legal(input logic [ALU_OP_W-1:0] op);
        return op <= ALU_OR;
    endfunction
endpackage

// File: rtl/alu.sv
// alu: shared combinational ALU with equality and illegal-opcode flags.
module alu
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [ALU_OP_W-1:0] op,
    input  logic [W-1:0]        a,
    input  logic [W-1:0]        b,
    output logic [W-1:0]        y,
    output logic                zero,
    output logic                err
);
    assign y = op == ALU_ADD ? a + b :
               op == ALU_SUB ? a - b :
               op == ALU_AND ? a & b :
               op == ALU_OR  ? a | b : '0;
    assign zero = a == b;
    assign err  = !alu_op_legal(op);
endmodule

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant; the pointer names who wins a tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] elig,
    output logic [1:0] grant
);
    logic rr;
    assign grant = &elig ? (rr ? 2'b10 : 2'b01) : elig;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rr <= 1'b0;
        else if (|grant) rr <= grant[0];
    end
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: two requesters share one ALU; results land in
// per-requester one-entry response registers with 1-cycle latency.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int W     = 32,
    parameter int TAG_W = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [ALU_OP_W-1:0] req_op0,
    input  logic [ALU_OP_W-1:0] req_op1,
    input  logic [W-1:0]        req_a0,
    input  logic [W-1:0]        req_b0,
    input  logic [W-1:0]        req_a1,
    input  logic [W-1:0]        req_b1,
    input  logic [TAG_W-1:0]    req_tag0,
    input  logic [TAG_W-1:0]    req_tag1,
    output logic [1:0]          rsp_valid,
    input  logic [1:0]          rsp_ready,
    output logic [W-1:0]        rsp_data0,
    output logic [W-1:0]        rsp_data1,
    output logic                rsp_zero0,
    output logic                rsp_zero1,
    output logic                rsp_err0,
    output logic                rsp_err1,
    output logic [TAG_W-1:0]    rsp_tag0,
    output logic [TAG_W-1:0]    rsp_tag1
);
    logic [1:0]          elig, grant, zero_q, err_q;
    logic [ALU_OP_W-1:0] op;
    logic [W-1:0]        a, b, y;
    logic [TAG_W-1:0]    tag;
    logic                zero, err;
    logic [W-1:0]        data_q [2];
    logic [TAG_W-1:0]    tag_q [2];
    // a slot draining this cycle may accept a new result back-to-back
    assign elig = req_valid & (~rsp_valid | rsp_ready) & {2{reset_n}};
    assign req_ready = grant;
    rr_arb2 u_arb (.clk(clk), .reset_n(reset_n), .elig(elig), .grant(grant));
    assign op  = grant[1] ? req_op1  : req_op0;
    assign a   = grant[1] ? req_a1   : req_a0;
    assign b   = grant[1] ? req_b1   : req_b0;
    assign tag = grant[1] ? req_tag1 : req_tag0;
    alu #(.W(W)) u_alu (.op(op), .a(a), .b(b), .y(y), .zero(zero), .err(err));
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= '0;
            zero_q    <= '0;
            err_q     <= '0;
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (grant[i]) begin
                    rsp_valid[i] <= 1'b1;
                    data_q[i]    <= y;
                    zero_q[i]    <= zero;
                    err_q[i]     <= err;
                    tag_q[i]     <= tag;
                end else if (rsp_ready[i]) begin
                    rsp_valid[i] <= 1'b0;
                end
            end
        end
    end
    assign rsp_data0 = data_q[0];
    assign rsp_data1 = data_q[1];
    assign rsp_tag0  = tag_q[0];
    assign rsp_tag1  = tag_q[1];
    assign rsp_zero0 = zero_q[0];
    assign rsp_zero1 = zero_q[1];
    assign rsp_err0  = err_q[0];
    assign rsp_err1  = err_q[1];
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed stimulus, reference model checked every cycle.
module tb_alu_share_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
    logic [2:0]  req_op0 = '0, req_op1 = '0;
    logic [31:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
    logic [3:0]  req_tag0 = '0, req_tag1 = '0, rsp_tag0, rsp_tag1;
    logic [31:0] rsp_data0, rsp_data1;
    logic        rsp_zero0, rsp_zero1, rsp_err0, rsp_err1;
    int n_checks = 0, n_fail = 0;

    alu_share_arbiter #(.W(32), .TAG_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(req_op0), .req_op1(req_op1), .req_a0(req_a0), .req_b0(req_b0),
        .req_a1(req_a1), .req_b1(req_b1), .req_tag0(req_tag0), .req_tag1(req_tag1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data0(rsp_data0),
        .rsp_data1(rsp_data1), .rsp_zero0(rsp_zero0), .rsp_zero1(rsp_zero1),
        .rsp_err0(rsp_err0), .rsp_err1(rsp_err1), .rsp_tag0(rsp_tag0), .rsp_tag1(rsp_tag1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: who wins, what each response slot holds
    int          m_prio;
    logic [1:0]  m_v;
    logic [31:0] m_d [2];
    logic        m_z [2], m_e [2];
    logic [3:0]  m_t [2];

    function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [1:0] m_grant();
        bit ok0, ok1;
        ok0 = reset_n && req_valid[0] && (!m_v[0] || rsp_ready[0]);
        ok1 = reset_n && req_valid[1] && (!m_v[1] || rsp_ready[1]);
        if (ok0 && ok1) return m_prio == 0 ? 2'b01 : 2'b10;
        if (ok0) return 2'b01;
        if (ok1) return 2'b10;
        return 2'b00;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        logic [1:0] g;
        if (!reset_n) begin
            m_prio = 0;
            m_v = 2'b00;
            for (int i = 0; i < 2; i++) begin
                m_d[i] = 0; m_z[i] = 0; m_e[i] = 0; m_t[i] = 0;
            end
        end else begin
            g = m_grant();
            if (g[0]) begin
                m_v[0] = 1; m_d[0] = alu_ref(req_op0, req_a0, req_b0);
                m_z[0] = req_a0 == req_b0; m_e[0] = req_op0 > 3; m_t[0] = req_tag0;
                m_prio = 1;
            end else if (rsp_ready[0]) m_v[0] = 0;
            if (g[1]) begin
                m_v[1] = 1; m_d[1] = alu_ref(req_op1, req_a1, req_b1);
                m_z[1] = req_a1 == req_b1; m_e[1] = req_op1 > 3; m_t[1] = req_tag1;
                m_prio = 0;
            end else if (rsp_ready[1]) m_v[1] = 0;
        end
    end

    always @(negedge clk) begin
        chk("model req_ready", req_ready, m_grant());
        chk("model rsp_valid", rsp_valid, m_v);
        chk("model rsp_data0", rsp_data0, m_d[0]);
        chk("model rsp_data1", rsp_data1, m_d[1]);
        chk("model rsp_zero0", rsp_zero0, m_z[0]);
        chk("model rsp_zero1", rsp_zero1, m_z[1]);
        chk("model rsp_err0", rsp_err0, m_e[0]);
        chk("model rsp_err1", rsp_err1, m_e[1]);
        chk("model rsp_tag0", rsp_tag0, m_t[0]);
        chk("model rsp_tag1", rsp_tag1, m_t[1]);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) step();
        reset_n = 1'b1;
        // single request
        req_valid = 2'b01; req_op0 = 3'd0; req_a0 = 5; req_b0 = 7; req_tag0 = 3;
        @(negedge clk) chk("single ready", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        @(negedge clk);
        chk("single valid", rsp_valid[0], 1);
        chk("single data", rsp_data0, 12);
        chk("single zero", rsp_zero0, 0);
        chk("single err", rsp_err0, 0);
        chk("single tag", rsp_tag0, 3);
        // contention right after a reset pulse
        #2 reset_n = 1'b0;
        #2 reset_n = 1'b1;
        step();
        rsp_ready = 2'b11; req_valid = 2'b11;
        req_op0 = 3'd1; req_a0 = 32'h10; req_b0 = 32'h10; req_tag0 = 1;
        req_op1 = 3'd3; req_a1 = 32'hF0; req_b1 = 32'h0F; req_tag1 = 2;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("contention grant", req_ready, (k % 2) ? 2'b10 : 2'b01);
            if (k == 1) begin
                chk("sub data", rsp_data0, 0);
                chk("sub zero", rsp_zero0, 1);
            end
            if (k == 2) chk("or data", rsp_data1, 32'hFF);
            step();
        end
        // backpressure on requester 1
        rsp_ready = 2'b00; req_valid = 2'b10; req_op1 = 3'd0; req_a1 = 1; req_b1 = 2; req_tag1 = 7;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("bp ready", req_ready, 2'b00);
            chk("bp hold data", rsp_data1, 32'hFF);
            step();
        end
        rsp_ready = 2'b10;
        @(negedge clk) chk("bp release grant", req_ready, 2'b10);
        step();
        req_valid = 2'b00;
        @(negedge clk);
        chk("bp overwrite valid", rsp_valid[1], 1);
        chk("bp overwrite data", rsp_data1, 3);
        chk("bp overwrite tag", rsp_tag1, 7);
        step();
        @(negedge clk) chk("bp drained", rsp_valid[1], 0);
        // wrap-around and illegal opcode
        rsp_ready = 2'b11; req_valid = 2'b01;
        req_op0 = 3'd0; req_a0 = 32'hFFFF_FFFF; req_b0 = 1; req_tag0 = 2;
        @(negedge clk) chk("wrap grant", req_ready, 2'b01);
        step();
        req_op0 = 3'd4; req_a0 = 9; req_b0 = 9; req_tag0 = 5;
        @(negedge clk);
        chk("wrap data", rsp_data0, 0);
        chk("wrap zero", rsp_zero0, 0);
        chk("wrap err", rsp_err0, 0);
        step();
        req_valid = 2'b00;
        @(negedge clk);
        chk("illegal data", rsp_data0, 0);
        chk("illegal err", rsp_err0, 1);
        chk("illegal zero", rsp_zero0, 1);
        chk("illegal tag", rsp_tag0, 5);
        // fill both slots, then reset mid-stream
        step();
        rsp_ready = 2'b00; req_valid = 2'b11;
        req_op0 = 3'd0; req_a0 = 1; req_b0 = 1; req_op1 = 3'd2; req_a1 = 6; req_b1 = 3;
        repeat (2) step();
        @(negedge clk);
        chk("full valid", rsp_valid, 2'b11);
        chk("full ready", req_ready, 2'b00);
        #2 reset_n = 1'b0;
        #1;
        chk("async rst valid", rsp_valid, 2'b00);
        chk("async rst data0", rsp_data0, 0);
        chk("async rst data1", rsp_data1, 0);
        chk("async rst tag1", rsp_tag1, 0);
        chk("async rst ready", req_ready, 2'b00);
        step();
        reset_n = 1'b1;
        @(negedge clk) chk("post reset grant", req_ready, 2'b01);
        step();
        @(negedge clk) chk("post reset second grant", req_ready, 2'b10);
        step();
        req_valid = 2'b00;
        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU between two requesters (port 0 = execute stage, port 1 = auxiliary address/compare logic).
- Each requester issues operations over a valid/ready handshake. A round-robin arbiter grants at most one operation per cycle to the ALU.
- The result is captured into a per-requester one-entry response register, which is drained with its own valid/ready handshake.

Parameters:
- W, 32, operand/result width.
- TAG_W, 4, width of the opaque request tag returned with the result.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester request valid (bit i = requester i).
- req_ready  out  2  per-requester request accepted this cycle.
- req_op0, req_op1  in  3 each  ALU opcode.
- req_a0, req_b0, req_a1, req_b1  in  W each  operands.
- req_tag0, req_tag1  in  TAG_W each  tags.
- rsp_valid  out  2  response register i holds a result.
- rsp_ready  in  2  requester i consumes its response.
- rsp_data0, rsp_data1  out  W each  result.
- rsp_zero0, rsp_zero1  out  1 each  A==B flag of the operation.
- rsp_err0, rsp_err1  out  1 each  illegal opcode flag.
- rsp_tag0, rsp_tag1  out  TAG_W each  echoed tag.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - rsp_valid=0; all rsp_data/tag/zero/err=0; round-robin pointer rr=0 (requester 0 has priority first).
  - req_ready=0 while reset_n=0.
- Opcodes:
  - 0 add, 1 sub, 2 and, 3 or; modulo-2^W arithmetic, no overflow flag.
  - Opcodes 4..7 are illegal: rsp_data=0, rsp_err=1, rsp_zero still computed as A==B.
  - Illegal ops are still accepted and still consume a grant.
- Eligibility: requester i is eligible when req_valid[i]=1 AND (rsp_valid[i]=0 OR rsp_ready[i]=1). Slot free or draining this cycle allows back-to-back issue.
- Arbitration:
  - Combinational from current-cycle inputs.
  - Only one eligible: grant it.
  - Both eligible: grant requester rr.
  - After any grant, rr <= the other requester. rr is unchanged on idle cycles.
- req_ready[i] = grant[i]. It is never asserted for an ineligible requester. A requester must hold op/a/b/tag stable while valid and not ready.
- Latency: the result appears in rsp register i on the edge where grant[i]=1, so rsp_valid[i] is high the following cycle (1-cycle latency). Throughput is one op per cycle aggregate.
- Response register i:
  - Set on grant[i].
  - Cleared on rsp_ready[i] & rsp_valid[i] without a simultaneous grant[i].
  - Simultaneous drain and grant: new result overwrites and rsp_valid stays 1.
  - rsp_ready while rsp_valid=0 has no effect.
- Response outputs come straight from registers, with no combinational path from req_* to rsp_*.
- Starvation bound: a continuously eligible requester is granted within 2 cycles.
- Reset mid-operation: the pending response is discarded, and requesters must reissue after release.
- The ALU is instantiated once; its op and operand muxes are selected by grant. With no grant, the ALU inputs are don't-care and no register updates.

Decomposition:
- Shared package alu_pkg: opcode constants ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3; constant ALU_OP_W=3; a helper predicate for legal opcodes.
- One natural sub-module: rr_arb2, a 2-way round-robin grant with rr pointer. The ALU itself is the existing shared combinational unit, instantiated, not reimplemented.

Test Plan:
- Single request: req0 add A=5,B=7,tag=3 → req_ready[0]=1 same cycle; next cycle rsp_valid[0]=1, rsp_data0=12, rsp_zero0=0, rsp_err0=0, rsp_tag0=3.
- Contention after reset, both requesters hold valid with rsp_ready=1:
  - Grants alternate 0,1,0,1.
  - req0 sub 0x10-0x10 → rsp_data0=0, rsp_zero0=1.
  - req1 or 0xF0|0x0F → rsp_data1=0xFF.
- Backpressure: rsp_valid[1]=1 with rsp_ready[1]=0 and req1 valid → req_ready[1]=0 and rsp_data1 unchanged. Raising rsp_ready[1] gives same-cycle grant, and the new result replaces the old with rsp_valid[1] staying 1.
- Wrap and illegal op:
  - add 0xFFFFFFFF+1 → rsp_data=0, rsp_zero=0.
  - op=4 with A=B=9 → rsp_data=0, rsp_err=1, rsp_zero=1.
- Reset mid-stream: assert reset_n=0 while rsp_valid=2'b11 and both req_valid → outputs zero asynchronously. After release, the first contention grants requester 0.
